// File: rtl/exe_unit_seq.sv
// Sequenced execute unit: single-cycle SLA/CMP/ADD/SUB and an iterative signed MUL.
// One result pulse on o_valid per accepted request, with results held between pulses.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | o_ready=1; single-cycle ops complete here, MUL moves to BUSY
// ST_BUSY | o_ready=0; one multiplier bit per edge, down-counter to zero
module exe_unit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rsn,
  input  logic             i_valid,
  input  logic [2:0]       i_oper,
  input  logic [WIDTH-1:0] i_argA,
  input  logic [WIDTH-1:0] i_argB,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [2:0]       o_status
);

  localparam int               CW          = $clog2(WIDTH);
  localparam logic [CW-1:0]    LP_CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] LP_WIDTH    = WIDTH'(WIDTH);

  typedef enum logic [2:0] {
    OP_SLA = 3'b000,
    OP_CMP = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_MUL = 3'b100
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e             r_state;
  logic               r_ready;
  logic               r_valid;
  logic [WIDTH-1:0]   r_result;
  logic [2:0]         r_status;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_shl;
  logic [WIDTH-1:0]   w_shl_back;
  logic               w_sla_err;
  logic               w_sla_ovf;
  logic               w_add_ovf;
  logic               w_sub_ovf;
  logic               w_cmp_gt;
  logic [WIDTH-1:0]   w_sc_result;
  logic               w_sc_err;
  logic               w_sc_ovf;
  logic               w_sc_zero;

  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_mul_addend;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_mul_ovf;
  logic               w_mul_zero;

  // Single-cycle datapath, evaluated on the live request operands
  always_comb begin
    w_sum      = i_argA + i_argB;
    w_diff     = i_argA - i_argB;
    w_sla_err  = i_argB[WIDTH-1] || (i_argB >= LP_WIDTH);
    w_shl      = i_argA << i_argB;
    // Shifting back arithmetically recovers A only if no significant bit was lost
    w_shl_back = $signed(w_shl) >>> i_argB;
    w_sla_ovf  = (w_shl_back != i_argA);
    w_add_ovf  = (i_argA[WIDTH-1] == i_argB[WIDTH-1]) && (w_sum[WIDTH-1] != i_argA[WIDTH-1]);
    w_sub_ovf  = (i_argA[WIDTH-1] != i_argB[WIDTH-1]) && (w_diff[WIDTH-1] != i_argA[WIDTH-1]);
    w_cmp_gt   = $signed(i_argA) > $signed(i_argB);

    w_sc_result = '0;
    w_sc_err    = 1'b0;
    w_sc_ovf    = 1'b0;
    case (i_oper)
      OP_SLA: begin
        if (w_sla_err) begin
          w_sc_err = 1'b1;
        end else begin
          w_sc_result = w_shl;
          w_sc_ovf    = w_sla_ovf;
        end
      end
      OP_CMP: w_sc_result = {{(WIDTH-1){1'b0}}, w_cmp_gt};
      OP_ADD: begin
        w_sc_result = w_sum;
        w_sc_ovf    = w_add_ovf;
      end
      OP_SUB: begin
        w_sc_result = w_diff;
        w_sc_ovf    = w_sub_ovf;
      end
      default: w_sc_err = 1'b1;
    endcase
    w_sc_zero = !w_sc_err && (w_sc_result == '0);
  end

  // Shift-add multiply; the sign bit of B carries negative weight, so the last step subtracts
  always_comb begin
    w_mul_last   = (r_cnt == '0);
    w_mul_addend = '0;
    if (r_mplier[0]) begin
      w_mul_addend = w_mul_last ? (~r_mcand + 1'b1) : r_mcand;
    end
    w_acc_next = r_acc + w_mul_addend;
    w_mul_ovf  = !((&w_acc_next[2*WIDTH-1:WIDTH-1]) || !(|w_acc_next[2*WIDTH-1:WIDTH-1]));
    w_mul_zero = (w_acc_next[WIDTH-1:0] == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rsn) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_status <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            if (i_oper == OP_MUL) begin
              r_state  <= ST_BUSY;
              r_ready  <= 1'b0;
              r_cnt    <= LP_CNT_LOAD;
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{i_argA[WIDTH-1]}}, i_argA};
              r_mplier <= i_argB;
            end else begin
              r_valid  <= 1'b1;
              r_result <= w_sc_result;
              r_status <= {w_sc_zero, w_sc_ovf, w_sc_err};
            end
          end
        end
        ST_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (w_mul_last) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b1;
            r_result <= w_acc_next[WIDTH-1:0];
            r_status <= {w_mul_zero, w_mul_ovf, 1'b0};
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
      endcase
    end
  end

  // Reset masks ready in the same cycle so a coincident request is never taken
  assign o_ready  = r_ready && !i_rsn;
  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_status = r_status;

endmodule

// File: tb/tb_exe_unit_seq.sv
// Bench for exe_unit_seq (WIDTH=8): directed cases plus random requests
// compared against an integer-arithmetic reference model.
module tb_exe_unit_seq;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rsn;
  logic         i_valid;
  logic [2:0]   i_oper;
  logic [W-1:0] i_argA;
  logic [W-1:0] i_argB;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_result;
  logic [2:0]   o_status;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  exe_unit_seq #(.WIDTH(W)) dut (
    .i_clk    (i_clk),
    .i_rsn    (i_rsn),
    .i_valid  (i_valid),
    .i_oper   (i_oper),
    .i_argA   (i_argA),
    .i_argB   (i_argB),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_status (o_status)
  );

  always #5 i_clk = ~i_clk;

  // Returns {zero, overflow, error, result}
  function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    longint sa, sb, r;
    logic   err, ovf, zero;
    logic [7:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = 0;
    err = 1'b0;
    case (op)
      3'd0: if (sb < 0 || sb >= W) err = 1'b1; else r = sa * (longint'(1) << sb);
      3'd1: r = (sa > sb) ? 1 : 0;
      3'd2: r = sa + sb;
      3'd3: r = sa - sb;
      3'd4: r = sa * sb;
      default: err = 1'b1;
    endcase
    ovf  = !err && (r > 127 || r < -128);
    res  = err ? 8'h00 : r[7:0];
    zero = !err && (res == 8'h00);
    return {zero, ovf, err, res};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Applies one request from an idle cycle and checks its result pulse and hold
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input string tag);
    logic [10:0] exp;
    exp = model(op, a, b);
    n_vec++;
    i_valid = 1'b1;
    i_oper  = op;
    i_argA  = a;
    i_argB  = b;
    step();
    i_valid = 1'b0;
    if (op == 3'd4) begin
      for (int c = 0; c < W; c++) begin
        chk({tag, "_busy_ready"}, 32'(o_ready), 32'(0));
        chk({tag, "_busy_valid"}, 32'(o_valid), 32'(0));
        i_valid = 1'($urandom_range(0, 1));
        i_oper  = 3'($urandom);
        i_argA  = 8'($urandom);
        i_argB  = 8'($urandom);
        step();
      end
      i_valid = 1'b0;
    end
    chk({tag, "_valid"},  32'(o_valid),  32'(1));
    chk({tag, "_ready"},  32'(o_ready),  32'(1));
    chk({tag, "_result"}, 32'(o_result), 32'(exp[7:0]));
    chk({tag, "_status"}, 32'(o_status), 32'(exp[10:8]));
    i_argA = 8'($urandom);
    i_argB = 8'($urandom);
    step();
    chk({tag, "_pulse_end"},   32'(o_valid),  32'(0));
    chk({tag, "_hold_result"}, 32'(o_result), 32'(exp[7:0]));
    chk({tag, "_hold_status"}, 32'(o_status), 32'(exp[10:8]));
  endtask

  initial begin
    logic [2:0]  b2b_op [5];
    logic [7:0]  b2b_a  [5];
    logic [7:0]  b2b_b  [5];
    logic [10:0] exp;
    logic [2:0]  r_op;
    logic [7:0]  r_a, r_b;

    // Reset with a coincident request that must be ignored
    i_rsn   = 1'b1;
    i_valid = 1'b1;
    i_oper  = 3'd1;
    i_argA  = 8'h03;
    i_argB  = 8'h00;
    step();
    step();
    chk("rst_ready",  32'(o_ready),  32'(0));
    chk("rst_valid",  32'(o_valid),  32'(0));
    chk("rst_result", 32'(o_result), 32'(0));
    chk("rst_status", 32'(o_status), 32'(0));
    i_rsn   = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("rel_ready", 32'(o_ready), 32'(1));
    step();
    chk("rel_no_valid", 32'(o_valid), 32'(0));

    do_op(3'd0, 8'h05, 8'h02, "sla_5_2");
    do_op(3'd0, 8'h05, 8'hFF, "sla_neg");
    do_op(3'd0, 8'h05, 8'h08, "sla_wide");
    do_op(3'd0, 8'h40, 8'h01, "sla_sign");
    do_op(3'd2, 8'h7F, 8'h01, "add_ovf");
    do_op(3'd3, 8'h05, 8'h05, "sub_zero");
    do_op(3'd3, 8'h80, 8'h01, "sub_ovf");
    do_op(3'd4, 8'hFD, 8'h04, "mul_neg");
    do_op(3'd4, 8'h10, 8'h10, "mul_ovf_zero");
    do_op(3'd4, 8'h80, 8'hFF, "mul_min");
    do_op(3'd7, 8'h12, 8'h34, "invalid");

    // Reset on the 4th busy edge aborts the multiply
    i_valid = 1'b1;
    i_oper  = 3'd4;
    i_argA  = 8'h07;
    i_argB  = 8'h05;
    step();
    i_valid = 1'b0;
    step();
    step();
    step();
    i_rsn   = 1'b1;
    i_valid = 1'b1;
    i_oper  = 3'd2;
    #1;
    chk("abort_ready_in_rst", 32'(o_ready), 32'(0));
    step();
    chk("abort_valid",  32'(o_valid),  32'(0));
    chk("abort_result", 32'(o_result), 32'(0));
    chk("abort_status", 32'(o_status), 32'(0));
    i_rsn   = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("abort_rel_ready", 32'(o_ready), 32'(1));
    for (int c = 0; c < W + 2; c++) begin
      step();
      chk("abort_no_valid", 32'(o_valid), 32'(0));
    end
    do_op(3'd1, 8'h03, 8'hFE, "cmp_after_abort");

    // Back-to-back single-cycle requests
    b2b_op = '{3'd1, 3'd2, 3'd6, 3'd1, 3'd2};
    b2b_a  = '{8'h03, 8'h7F, 8'h12, 8'h80, 8'h10};
    b2b_b  = '{8'hFE, 8'h01, 8'h34, 8'h7F, 8'hF0};
    for (int i = 0; i < 5; i++) begin
      exp     = model(b2b_op[i], b2b_a[i], b2b_b[i]);
      n_vec++;
      i_valid = 1'b1;
      i_oper  = b2b_op[i];
      i_argA  = b2b_a[i];
      i_argB  = b2b_b[i];
      step();
      chk("b2b_valid",  32'(o_valid),  32'(1));
      chk("b2b_result", 32'(o_result), 32'(exp[7:0]));
      chk("b2b_status", 32'(o_status), 32'(exp[10:8]));
    end
    i_valid = 1'b0;
    step();
    chk("b2b_end", 32'(o_valid), 32'(0));

    // Random requests
    for (int n = 0; n < 300; n++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = 8'($urandom);
      r_b  = 8'($urandom);
      if (r_op == 3'd0 && $urandom_range(0, 1) == 1) r_b = 8'($urandom_range(0, 9));
      do_op(r_op, r_a, r_b, "rand");
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exe_unit_seq.md
EXE_UNIT_SEQ -- requirements
Module: exe_unit_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be supported for 4..32.
REQ-002 i_clk  input  1  sole clock; all state SHALL update on rising edge only.
REQ-003 i_rsn  input  1  reset; SHALL be synchronous and active-high (sampled on i_clk rising edge, 1 = reset).
REQ-004 i_valid  input  1  request strobe; request SHALL be accepted on an edge where i_valid=1 and o_ready=1.
REQ-005 i_oper  input  3  opcode, sampled at acceptance.
REQ-006 i_argA  input  WIDTH  operand A, two's complement, sampled at acceptance.
REQ-007 i_argB  input  WIDTH  operand B, two's complement, sampled at acceptance.
REQ-008 o_ready  output  1  unit can accept a request this cycle.
REQ-009 o_valid  output  1  one-cycle pulse, o_result/o_status valid.
REQ-010 o_result  output  WIDTH  registered result.
REQ-011 o_status  output  3  registered status: bit0 error, bit1 overflow, bit2 zero.

Function
REQ-012 Opcodes SHALL be: 000 SLA, 001 CMP, 010 ADD, 011 SUB, 100 MUL; 101..111 invalid.
REQ-013 SLA: result = A shifted left by B bits, zero fill; B<0 or B>=WIDTH -> error.
REQ-014 SLA overflow SHALL be set when any shifted-out bit or the new sign bit differs from A's original sign.
REQ-015 CMP: result = 1 if A>B signed, else 0; overflow=0.
REQ-016 ADD/SUB: result = low WIDTH bits of A+B / A-B; overflow on signed overflow.
REQ-017 MUL: result = low WIDTH bits of signed A*B; overflow when the 2*WIDTH-bit product is not representable in WIDTH bits signed.
REQ-018 MUL SHALL be iterative, one bit of B per cycle, WIDTH iteration cycles.
REQ-019 Invalid opcode or error: o_result SHALL be 0, o_status = 001 (overflow and zero cleared).
REQ-020 Zero bit SHALL be 1 iff o_result=0 and error=0; it is independent of overflow.
REQ-021 FSM states SHALL be IDLE and BUSY.
REQ-022 IDLE: o_ready=1. Accepting SLA/CMP/ADD/SUB/invalid stays in IDLE. Accepting MUL moves to BUSY.
REQ-023 BUSY: o_ready=0; iteration counter counts WIDTH edges, then returns to IDLE.
REQ-024 Single-cycle op accepted at edge k: o_valid=1 during the cycle after edge k.
REQ-025 MUL accepted at edge k: o_valid=1 during the cycle after edge k+WIDTH; o_ready=1 in that same cycle.
REQ-026 Back-to-back single-cycle requests SHALL be accepted every cycle, each producing one o_valid pulse.
REQ-027 i_valid while o_ready=0 SHALL be ignored (not queued).
REQ-028 Operand inputs changing during BUSY SHALL NOT affect the MUL result.
REQ-029 No output backpressure: o_valid lasts exactly one cycle per accepted request.
REQ-030 o_result/o_status SHALL hold their last value while o_valid=0.

Reset
REQ-031 i_rsn=1 at an edge SHALL force IDLE, counter=0, o_valid=0, o_result=0, o_status=000.
REQ-032 o_ready SHALL be 0 in any cycle where i_rsn=1, and 1 from the first cycle after i_rsn returns to 0.
REQ-033 Reset during BUSY SHALL abort the MUL; no o_valid is produced for it.
REQ-034 i_valid coincident with i_rsn=1 SHALL be ignored.

Verification (WIDTH=8)
REQ-035 SLA A=05 B=02 -> next cycle o_result=14, o_status=000. SLA A=05 B=FF -> o_result=00, o_status=001.
REQ-036 ADD A=7F B=01 -> o_result=80, o_status=010. SUB A=05 B=05 -> o_result=00, o_status=100.
REQ-037 MUL A=FD B=04 accepted at edge k:
- o_ready=0 for cycles after edges k..k+7;
- o_valid only in the cycle after edge k+8, with o_result=F4, o_status=000.
REQ-038 MUL A=10 B=10 -> o_result=00, o_status=110. MUL A=80 B=FF -> o_result=80, o_status=010.
REQ-039 MUL accepted, i_rsn=1 at the 4th busy edge:
- no o_valid is produced;
- outputs are 0;
- o_ready=1 the cycle after reset releases;
- a CMP A=03 B=FE accepted next -> o_result=01, o_status=000.
REQ-040 Five consecutive CMP/ADD/invalid(110) requests -> five consecutive o_valid pulses with matching results; invalid op gives o_status=001.
